uart_mem_cmd_ctrl: RTL

Byte-stream command controller between the UART RX/TX byte interfaces and the single-port memory (write_En/read_En/Address/Data_in/Data_out/Valid_out).
- Parses command frames from RX bytes.
- Sequences memory write and read cycles.
- Serialises read data back to UART TX, LSB byte first.
- Reports malformed, aborted and timed-out frames.

---
 rtl/uart_mem_cmd_pkg.sv | 23 ++
 rtl/uart_mem_cmd_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_cmd_pkg.sv
// Shared types and constants for the UART-to-memory command controller.
package uart_mem_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        MEM_WR,
        MEM_RD,
        WAIT_VALID,
        TX
    } state_t;

    // Command byte opcode field, bits [7:6]
    localparam logic [1:0] OP_WR = 2'b00;
    localparam logic [1:0] OP_RD = 2'b01;

    // err_code values
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_OPCODE  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_RX      = 2'd3;

endpackage

// File: rtl/uart_mem_cmd_ctrl.sv
// Byte-stream command controller between a UART RX/TX byte interface and a
// single-port memory. Parses command frames, issues one memory write or read
// per frame, streams read data back LSB byte first, and flags bad opcodes,
// timeouts, receive errors and overruns.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   rx_valid/rx_data/rx_error  received byte strobe, byte, error qualifier
//   tx_valid/tx_data/tx_ready  outgoing byte with valid/ready handshake
//   mem_wr_en/mem_rd_en/mem_addr/mem_wdata  memory command
//   mem_rdata/mem_valid      memory read response
//   busy                     high whenever the FSM is not IDLE
//   err/err_code             one-cycle error pulse; code held until next pulse
module uart_mem_cmd_ctrl
    import uart_mem_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_DEPTH      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    localparam int unsigned ADDR_WIDTH    = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rx_error,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid,
    output logic                  busy,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_n;
    logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_n;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_n;
    logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_n;

    logic                    tx_valid_n;
    logic                    mem_wr_en_n;
    logic                    mem_rd_en_n;
    logic [ADDR_WIDTH-1:0]   mem_addr_n;
    logic [DATA_WIDTH-1:0]   mem_wdata_n;
    logic                    busy_n;
    logic                    err_n;
    logic [1:0]              err_code_n;

    logic                    ev_rx;
    logic                    ev_tmo;
    logic                    ev_op;
    logic                    tx_hs;

    // The current TX byte is always the low byte of the shift register.
    assign tx_data = tx_sh_q[7:0];
    assign tx_hs   = tx_valid && tx_ready;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            tx_sh_q    <= '0;
            tx_valid   <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state_q    <= state_n;
            byte_cnt_q <= byte_cnt_n;
            tmo_cnt_q  <= tmo_cnt_n;
            tx_sh_q    <= tx_sh_n;
            tx_valid   <= tx_valid_n;
            mem_wr_en  <= mem_wr_en_n;
            mem_rd_en  <= mem_rd_en_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            busy       <= busy_n;
            err        <= err_n;
            err_code   <= err_code_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state_q;
        byte_cnt_n  = byte_cnt_q;
        tmo_cnt_n   = tmo_cnt_q;
        tx_sh_n     = tx_sh_q;
        tx_valid_n  = tx_valid;
        mem_wr_en_n = 1'b0;
        mem_rd_en_n = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        err_n       = 1'b0;
        err_code_n  = err_code;
        ev_rx       = 1'b0;
        ev_tmo      = 1'b0;
        ev_op       = 1'b0;

        unique case (state_q)
            IDLE: begin
                tmo_cnt_n = '0;
                if (rx_valid) begin
                    if (rx_error) begin
                        ev_rx = 1'b1;
                    end else if (rx_data[7:6] == OP_WR) begin
                        mem_addr_n = rx_data[ADDR_WIDTH-1:0];
                        byte_cnt_n = '0;
                        state_n    = GET_DATA;
                    end else if (rx_data[7:6] == OP_RD) begin
                        mem_addr_n  = rx_data[ADDR_WIDTH-1:0];
                        byte_cnt_n  = '0;
                        mem_rd_en_n = 1'b1;
                        state_n     = MEM_RD;
                    end else begin
                        ev_op = 1'b1;
                    end
                end
            end

            GET_DATA: begin
                if (rx_valid) begin
                    tmo_cnt_n = '0;
                    if (rx_error) begin
                        ev_rx   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        for (int unsigned i = 0; i < BYTES; i++) begin
                            if (byte_cnt_q == CNT_W'(i)) begin
                                mem_wdata_n[8*i +: 8] = rx_data;
                            end
                        end
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_n  = '0;
                            mem_wr_en_n = 1'b1;
                            state_n     = MEM_WR;
                        end else begin
                            byte_cnt_n = byte_cnt_q + 1'b1;
                        end
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    ev_tmo  = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt_q + 1'b1;
                end
            end

            MEM_WR: begin
                ev_rx   = rx_valid;
                state_n = IDLE;
            end

            MEM_RD: begin
                ev_rx     = rx_valid;
                tmo_cnt_n = '0;
                state_n   = WAIT_VALID;
            end

            WAIT_VALID: begin
                ev_rx = rx_valid;
                if (mem_valid) begin
                    tx_sh_n    = mem_rdata;
                    tx_valid_n = 1'b1;
                    byte_cnt_n = '0;
                    state_n    = TX;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    ev_tmo  = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt_q + 1'b1;
                end
            end

            TX: begin
                ev_rx = rx_valid;
                if (tx_hs) begin
                    tx_sh_n = tx_sh_q >> 8;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_n = '0;
                        tx_valid_n = 1'b0;
                        state_n    = IDLE;
                    end else begin
                        byte_cnt_n = byte_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_n    = IDLE;
                tx_valid_n = 1'b0;
            end
        endcase

        // At most one error pulse per cycle; receive faults win over timeout
        if (ev_rx) begin
            err_n      = 1'b1;
            err_code_n = ERR_RX;
        end else if (ev_tmo) begin
            err_n      = 1'b1;
            err_code_n = ERR_TIMEOUT;
        end else if (ev_op) begin
            err_n      = 1'b1;
            err_code_n = ERR_OPCODE;
        end

        busy_n = (state_n != IDLE);
    end

endmodule
